// File: rtl/cfg_bitstream_loader.sv
// Streams a NUM_WORDS bitstream image from synchronous ROM into the fabric config port, then waits for fabric done.
// Latency: 3 cycles/word minimum; holds bit_v_o/bit_o until bit_r_i; TIMEOUT stall cycles in SEND/WAIT_DONE -> ERROR.
module cfg_bitstream_loader #(
    parameter int WORD_W    = 77,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic [WORD_W-1:0] bit_o,
    output logic              bit_v_o,
    input  logic              bit_r_i,
    input  logic              cfg_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT_DONE, S_DONE, S_ERROR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] bit_q;
    logic              mem_en_q;
    logic              bit_v_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;
    logic [TMO_W-1:0]  tmo_q;

    assign mem_en_o   = mem_en_q;
    assign mem_addr_o = idx_q;
    assign bit_o      = bit_q;
    assign bit_v_o    = bit_v_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign words_o    = words_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            bit_q    <= '0;
            mem_en_q <= 1'b0;
            bit_v_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            words_q  <= '0;
            tmo_q    <= '0;
        end else if (abort_i) begin
            // A word on the wire in the abort cycle still lands if the fabric takes it.
            if (state_q == S_SEND && bit_r_i)
                words_q <= words_q + (ADDR_W+1)'(1);
            state_q  <= S_IDLE;
            mem_en_q <= 1'b0;
            bit_v_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state_q  <= S_FETCH;
                        idx_q    <= '0;
                        words_q  <= '0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        tmo_q    <= '0;
                        mem_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q  <= S_LOAD;
                    mem_en_q <= 1'b0;
                    tmo_q    <= '0;
                end
                S_LOAD: begin
                    state_q <= S_SEND;
                    bit_q   <= mem_data_i;
                    bit_v_q <= 1'b1;
                    tmo_q   <= '0;
                end
                S_SEND: begin
                    if (bit_r_i) begin
                        bit_v_q <= 1'b0;
                        words_q <= words_q + (ADDR_W+1)'(1);
                        tmo_q   <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_WAIT_DONE;
                        end else begin
                            idx_q    <= idx_q + ADDR_W'(1);
                            state_q  <= S_FETCH;
                            mem_en_q <= 1'b1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                        bit_v_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (cfg_done_i) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: scenario table, hand-written abort/reset/start-while-busy sequences,
// and randomized loads checked against a transaction-level model of word order and load duration.
module tb_cfg_bitstream_loader;

    localparam int WORD_W    = 77;
    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int TIMEOUT   = 255;
    localparam int NEVER     = 100000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i, abort_i;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WORD_W-1:0] mem_data_i;
    logic [WORD_W-1:0] bit_o;
    logic              bit_v_o, bit_r_i, cfg_done_i;
    logic              busy_o, done_o, err_o;
    logic [ADDR_W:0]   words_o;

    cfg_bitstream_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .bit_o(bit_o), .bit_v_o(bit_v_o), .bit_r_i(bit_r_i), .cfg_done_i(cfg_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] rom [NUM_WORDS];
    always @(posedge clk) if (mem_en_o) mem_data_i <= rom[mem_addr_o];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_rom();
        logic [95:0] tmp;
        for (int i = 0; i < NUM_WORDS; i++) begin
            tmp = {$urandom(), $urandom(), $urandom()};
            rom[i] = tmp[WORD_W-1:0];
        end
    endtask

    // One full load. cyc = edges after the start edge until done_o/err_o is seen.
    task automatic run_load(input int stall_word, input int stall_len, input int done_delay,
                            input bit rnd, output int cyc, output int stalls, output int xfer);
        int last_xfer, stalled;
        logic [WORD_W-1:0] prev;
        bit prev_v;
        @(negedge clk);
        start_i = 1'b1; bit_r_i = 1'b0; cfg_done_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0; xfer = 0; stalled = 0; stalls = 0; last_xfer = 0; prev_v = 1'b0; prev = '0;
        while (!(done_o || err_o) && cyc < 2000) begin
            if (prev_v && bit_v_o) chk("bit_o_stable", bit_o, prev);
            if (rnd) bit_r_i = ($urandom_range(3) != 0);
            else     bit_r_i = !(xfer == stall_word && stalled < stall_len);
            prev_v = 1'b0;
            if (bit_v_o) begin
                if (bit_r_i) begin
                    chk($sformatf("word_data[%0d]", xfer), bit_o, rom[xfer]);
                    xfer++;
                    last_xfer = cyc + 1;
                end else begin
                    stalls++;
                    stalled++;
                    prev_v = 1'b1;
                    prev = bit_o;
                end
            end
            cfg_done_i = (xfer == NUM_WORDS && cyc + 1 >= last_xfer + done_delay);
            start_i = rnd && busy_o && ($urandom_range(7) == 0);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0; cfg_done_i = 1'b0; bit_r_i = 1'b0;
        if (cyc >= 2000) begin
            errors++;
            checks++;
            $display("FAIL load_budget: got no done/err within %0d cycles, required one", cyc);
        end
    endtask

    // Start a load and stop at the negedge where word w is being offered.
    task automatic advance_to_word(input int w);
        int xfer = 0;
        int n = 0;
        @(negedge clk);
        start_i = 1'b1; bit_r_i = 1'b1; cfg_done_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        while (!(bit_v_o && xfer == w) && n < 500) begin
            bit_r_i = 1'b1;
            if (bit_v_o) xfer++;
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            errors++;
            checks++;
            $display("FAIL advance_budget: got word %0d, required word %0d offered", xfer, w);
        end
    endtask

    typedef struct {
        int sw; int sl; int dd;
        bit exp_done; bit exp_err; int exp_words; int exp_cyc;
    } vec_t;

    vec_t vt [7];

    initial begin
        int cyc, stalls, xfer, dd;

        vt[0] = '{sw: 0,  sl: 0,     dd: 2,     exp_done: 1, exp_err: 0, exp_words: 16, exp_cyc: 50};
        vt[1] = '{sw: 3,  sl: 5,     dd: 2,     exp_done: 1, exp_err: 0, exp_words: 16, exp_cyc: 55};
        vt[2] = '{sw: 7,  sl: NEVER, dd: 2,     exp_done: 0, exp_err: 1, exp_words: 7,  exp_cyc: 278};
        vt[3] = '{sw: 0,  sl: 0,     dd: NEVER, exp_done: 0, exp_err: 1, exp_words: 16, exp_cyc: 303};
        vt[4] = '{sw: 0,  sl: 254,   dd: 1,     exp_done: 1, exp_err: 0, exp_words: 16, exp_cyc: 303};
        vt[5] = '{sw: 15, sl: 255,   dd: 2,     exp_done: 0, exp_err: 1, exp_words: 15, exp_cyc: 302};
        vt[6] = '{sw: 0,  sl: 0,     dd: 1,     exp_done: 1, exp_err: 0, exp_words: 16, exp_cyc: 49};

        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; bit_r_i = 1'b0; cfg_done_i = 1'b0;
        fill_rom();
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_bit_o", bit_o, 0);
        chk("rst_bit_v", bit_v_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_words", words_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fill_rom();
            run_load(vt[i].sw, vt[i].sl, vt[i].dd, 1'b0, cyc, stalls, xfer);
            chk($sformatf("v%0d_done", i), done_o, vt[i].exp_done);
            chk($sformatf("v%0d_err", i), err_o, vt[i].exp_err);
            chk($sformatf("v%0d_words", i), words_o, vt[i].exp_words);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cyc);
            chk($sformatf("v%0d_busy", i), busy_o, 0);
            chk($sformatf("v%0d_bit_v", i), bit_v_o, 0);
        end

        // Abort during word 9 with the fabric not ready.
        fill_rom();
        advance_to_word(9);
        abort_i = 1'b1; bit_r_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_words", words_o, 9);
        chk("abort_bit_v", bit_v_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        repeat (2) @(negedge clk);
        chk("abort_idle_bit_v", bit_v_o, 0);

        // Abort during word 4 with the fabric ready: that word still counts.
        advance_to_word(4);
        abort_i = 1'b1; bit_r_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; bit_r_i = 1'b0;
        chk("abort_xfer_words", words_o, 5);
        chk("abort_xfer_busy", busy_o, 0);

        // Restart after abort begins again at address 0.
        run_load(0, 0, 3, 1'b0, cyc, stalls, xfer);
        chk("restart_done", done_o, 1);
        chk("restart_words", words_o, 16);
        chk("restart_cycles", cyc, 51);

        // Start held during busy is ignored.
        advance_to_word(2);
        start_i = 1'b1; bit_r_i = 1'b1;
        @(negedge clk);
        chk("busy_start_addr", mem_addr_o, 3);
        chk("busy_start_mem_en", mem_en_o, 1);
        chk("busy_start_words", words_o, 3);
        @(negedge clk);
        chk("busy_start_addr2", mem_addr_o, 3);
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;

        // Reset mid-load clears outputs without waiting for a clock edge.
        advance_to_word(5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bit_v", bit_v_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_words", words_o, 0);
        chk("mid_rst_bit_o", bit_o, 0);
        chk("mid_rst_addr", mem_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Random ready/done timing: every word in order, 3 cycles/word plus stalls plus done latency.
        for (int r = 0; r < 8; r++) begin
            fill_rom();
            dd = $urandom_range(10, 1);
            run_load(0, 0, dd, 1'b1, cyc, stalls, xfer);
            chk($sformatf("rand%0d_done", r), done_o, 1);
            chk($sformatf("rand%0d_xfers", r), xfer, NUM_WORDS);
            chk($sformatf("rand%0d_words", r), words_o, NUM_WORDS);
            chk($sformatf("rand%0d_cycles", r), cyc, 3 * NUM_WORDS + stalls + dd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
